disp_min_stage: RTL and testbench

DISP_MIN_STAGE -- requirements
Module: disp_min_stage

---
 rtl/disp_pkg.sv | 31 +++
 rtl/disp_min_stage_if.sv | 41 ++++
 rtl/disp_delay_line.sv | 36 +++
 rtl/disp_min_stage.sv | 106 ++++++++++
 tb/tb_disp_min_stage.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Brief    : Shared sizes, types and helpers for the disparity minimum stage.
// Revision : 1.0 - initial release
// ============================================================================
package disp_pkg;

  localparam int DISP_RANGE  = 108;
  localparam int PIXEL_WIDTH = 8;
  localparam int DIM_WIDTH   = 10;
  localparam int DELAY_DEEP  = 8;
  localparam int COST_WIDTH  = DISP_RANGE * PIXEL_WIDTH;
  localparam int IDX_WIDTH   = 8;

  // Index carried by the padding slot of an odd-sized level; it always loses
  // ties because it is larger than every real index.
  localparam logic [IDX_WIDTH-1:0] PAD_IDX = {IDX_WIDTH{1'b1}};

  // Number of candidates left after 'lvl' pairwise reduction levels.
  function automatic int lvl_cnt(input int n, input int lvl);
    int c;
    c = n;
    for (int s = 0; s < lvl; s++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_min_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_min_stage_if
// Brief    : Sample input bus and result output bus of the minimum stage.
// Revision : 1.0 - initial release
// ============================================================================
interface disp_min_stage_if #(
  parameter int DISP_RANGE  = disp_pkg::DISP_RANGE,
  parameter int PIXEL_WIDTH = disp_pkg::PIXEL_WIDTH,
  parameter int DIM_WIDTH   = disp_pkg::DIM_WIDTH,
  parameter int IDX_WIDTH   = disp_pkg::IDX_WIDTH
);

  localparam int COST_WIDTH = DISP_RANGE * PIXEL_WIDTH;

  // Sample side
  logic                   en;
  logic [COST_WIDTH-1:0]  cost_aggr;
  logic [DIM_WIDTH-1:0]   row_in;
  logic [DIM_WIDTH-1:0]   col_in;

  // Result side
  logic [PIXEL_WIDTH-1:0] min_cost;
  logic [IDX_WIDTH-1:0]   min_cost_pos;
  logic [COST_WIDTH-1:0]  cost_aggr_out;
  logic [DIM_WIDTH-1:0]   row_out;
  logic [DIM_WIDTH-1:0]   col_out;
  logic                   valid;

  modport master (
    output en, cost_aggr, row_in, col_in,
    input  min_cost, min_cost_pos, cost_aggr_out, row_out, col_out, valid
  );

  modport slave (
    input  en, cost_aggr, row_in, col_in,
    output min_cost, min_cost_pos, cost_aggr_out, row_out, col_out, valid
  );

endinterface
`default_nettype wire

// File: rtl/disp_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : disp_delay_line
// Brief    : Fixed-depth shift register with asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module disp_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Shift every cycle; reset clears every tap so nothing in flight survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_pipe[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/disp_min_stage.sv
`default_nettype none
// ============================================================================
// Module   : disp_min_stage
// Brief    : Pipelined arg-min over DISP_RANGE aggregated costs per pixel,
//            with the sample data delayed to stay aligned with the result.
// Revision : 1.0 - initial release
// ============================================================================
module disp_min_stage #(
  parameter int DISP_RANGE  = disp_pkg::DISP_RANGE,
  parameter int PIXEL_WIDTH = disp_pkg::PIXEL_WIDTH,
  parameter int DIM_WIDTH   = disp_pkg::DIM_WIDTH,
  parameter int DELAY_DEEP  = disp_pkg::DELAY_DEEP
) (
  input wire logic         clk,
  input wire logic         rst,
  disp_min_stage_if.slave  bus
);

  import disp_pkg::*;

  localparam int CW = DISP_RANGE * PIXEL_WIDTH;
  localparam int DW = CW + 2 * DIM_WIDTH + 1;

  // Level 0 registers the raw entries with their indices; every later level
  // halves the candidate count. DELAY_DEEP must equal the number of levels
  // needed to reach a single candidate (8 for 108 entries).
  for (genvar l = 0; l < DELAY_DEEP; l++) begin : g_lvl
    localparam int N = lvl_cnt(DISP_RANGE, l);

    logic [PIXEL_WIDTH-1:0] r_cost [N];
    logic [IDX_WIDTH-1:0]   r_idx  [N];
    logic [PIXEL_WIDTH-1:0] w_cost [N];
    logic [IDX_WIDTH-1:0]   w_idx  [N];

    if (l == 0) begin : g_load
      for (genvar i = 0; i < N; i++) begin : g_ent
        assign w_cost[i] = bus.cost_aggr[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign w_idx[i]  = IDX_WIDTH'(i);
      end
    end else begin : g_reduce
      localparam int NP = lvl_cnt(DISP_RANGE, l - 1);

      for (genvar j = 0; j < N; j++) begin : g_node
        logic [PIXEL_WIDTH-1:0] w_ca;
        logic [PIXEL_WIDTH-1:0] w_cb;
        logic [IDX_WIDTH-1:0]   w_ia;
        logic [IDX_WIDTH-1:0]   w_ib;
        logic                   w_take_b;

        assign w_ca = g_lvl[l-1].r_cost[2*j];
        assign w_ia = g_lvl[l-1].r_idx[2*j];

        if (2 * j + 1 < NP) begin : g_pair
          assign w_cb = g_lvl[l-1].r_cost[2*j+1];
          assign w_ib = g_lvl[l-1].r_idx[2*j+1];
        end else begin : g_pad
          assign w_cb = {PIXEL_WIDTH{1'b1}};
          assign w_ib = PAD_IDX;
        end

        // Strictly smaller cost wins; on equal cost the lower index wins,
        // so the tree reports the lowest index holding the minimum.
        assign w_take_b = (w_cb < w_ca) || ((w_cb == w_ca) && (w_ib < w_ia));
        assign w_cost[j] = w_take_b ? w_cb : w_ca;
        assign w_idx[j]  = w_take_b ? w_ib : w_ia;
      end
    end

    // Level register: free-running, reset to a "no winner yet" value.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          r_cost[k] <= {PIXEL_WIDTH{1'b1}};
          r_idx[k]  <= '0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          r_cost[k] <= w_cost[k];
          r_idx[k]  <= w_idx[k];
        end
      end
    end
  end

  assign bus.min_cost     = g_lvl[DELAY_DEEP-1].r_cost[0];
  assign bus.min_cost_pos = g_lvl[DELAY_DEEP-1].r_idx[0];

  logic [DW-1:0] w_dl_in;
  logic [DW-1:0] w_dl_out;

  assign w_dl_in = {bus.cost_aggr, bus.row_in, bus.col_in, bus.en};

  disp_delay_line #(
    .WIDTH (DW),
    .DEPTH (DELAY_DEEP)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .i_data (w_dl_in),
    .o_data (w_dl_out)
  );

  assign {bus.cost_aggr_out, bus.row_out, bus.col_out, bus.valid} = w_dl_out;

endmodule
`default_nettype wire

// File: tb/tb_disp_min_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_min_stage
// Brief    : Directed self-checking bench for disp_min_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_min_stage;

  import disp_pkg::*;

  localparam int CW = COST_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [CW-1:0] v;
  bit   pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  disp_min_stage_if u_if ();

  disp_min_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed(lo64) %0h expected(lo64) %0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [CW-1:0] fill(input logic [7:0] bg);
    logic [CW-1:0] r;
    for (int i = 0; i < DISP_RANGE; i++) begin
      r[i*8 +: 8] = bg;
    end
    return r;
  endfunction

  task automatic drive(input logic [CW-1:0] vec, input logic e,
                       input logic [9:0] r, input logic [9:0] c);
    u_if.cost_aggr = vec;
    u_if.en        = e;
    u_if.row_in    = r;
    u_if.col_in    = c;
  endtask

  // One isolated sample, followed by en-low filler, checked at 7 and 8 cycles.
  task automatic single(input string tag, input logic [CW-1:0] vec,
                        input logic [7:0] ec, input logic [7:0] ep,
                        input logic [9:0] r, input logic [9:0] c);
    drive(vec, 1'b1, r, c);
    tick();
    drive(fill(8'h11), 1'b0, 10'd0, 10'd0);
    repeat (6) tick();
    chk({tag, "_early_valid"}, 32'(u_if.valid), 32'd0);
    tick();
    chk({tag, "_cost"},  32'(u_if.min_cost),     32'(ec));
    chk({tag, "_pos"},   32'(u_if.min_cost_pos), 32'(ep));
    chk({tag, "_valid"}, 32'(u_if.valid),        32'd1);
    chk({tag, "_row"},   32'(u_if.row_out),      32'(r));
    chk({tag, "_col"},   32'(u_if.col_out),      32'(c));
    chk_vec({tag, "_data"}, u_if.cost_aggr_out, vec);
  endtask

  initial begin
    // Reset state
    drive('0, 1'b0, 10'd0, 10'd0);
    tick();
    tick();
    chk("rst_cost",  32'(u_if.min_cost),     32'hFF);
    chk("rst_pos",   32'(u_if.min_cost_pos), 32'd0);
    chk("rst_valid", 32'(u_if.valid),        32'd0);
    chk("rst_row",   32'(u_if.row_out),      32'd0);
    chk("rst_col",   32'(u_if.col_out),      32'd0);
    chk_vec("rst_data", u_if.cost_aggr_out, '0);
    rst = 1'b1;
    tick();

    // Single minimum in the middle
    v = fill(8'h80);
    v[37*8 +: 8] = 8'h05;
    single("t_mid", v, 8'h05, 8'd37, 10'd12, 10'd300);

    // Tie: lower index wins
    v = fill(8'h40);
    v[10*8 +: 8] = 8'h02;
    v[90*8 +: 8] = 8'h02;
    single("t_tie", v, 8'h02, 8'd10, 10'd1, 10'd2);

    // Last entry, next to the padding slots
    v = fill(8'hFF);
    v[107*8 +: 8] = 8'h00;
    single("t_last", v, 8'h00, 8'd107, 10'd1023, 10'd5);

    // First entry
    v = fill(8'hFF);
    v[7:0] = 8'h00;
    single("t_first", v, 8'h00, 8'd0, 10'd3, 10'd1023);

    // All saturated: padding must never win
    v = fill(8'hFF);
    single("t_allff", v, 8'hFF, 8'd0, 10'd9, 10'd9);

    // Back-to-back stream with en toggling
    for (int k = 0; k < 8; k++) begin
      v = fill(8'h80);
      v[k*8 +: 8] = 8'(k);
      drive(v, pat[k], 10'(k), 10'(100 + k));
      tick();
    end
    drive(fill(8'h11), 1'b0, 10'd0, 10'd0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t_stream%0d_cost", k),  32'(u_if.min_cost),     32'(k));
      chk($sformatf("t_stream%0d_pos", k),   32'(u_if.min_cost_pos), 32'(k));
      chk($sformatf("t_stream%0d_valid", k), 32'(u_if.valid),        32'(pat[k]));
      chk($sformatf("t_stream%0d_row", k),   32'(u_if.row_out),      32'(k));
      chk($sformatf("t_stream%0d_col", k),   32'(u_if.col_out),      32'(100 + k));
      tick();
    end

    // Mid-stream reset flushes everything in flight
    v = fill(8'h80);
    v[20*8 +: 8] = 8'h01;
    for (int k = 0; k < 4; k++) begin
      drive(v, 1'b1, 10'd77, 10'd88);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("t_rst_valid", 32'(u_if.valid),        32'd0);
    chk("t_rst_cost",  32'(u_if.min_cost),     32'hFF);
    chk("t_rst_pos",   32'(u_if.min_cost_pos), 32'd0);
    chk("t_rst_row",   32'(u_if.row_out),      32'd0);
    chk("t_rst_col",   32'(u_if.col_out),      32'd0);
    chk_vec("t_rst_data", u_if.cost_aggr_out, '0);
    tick();
    tick();
    rst = 1'b1;
    drive(fill(8'h11), 1'b0, 10'd0, 10'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t_flush%0d_valid", k), 32'(u_if.valid), 32'd0);
    end

    // First sample after the reset
    v = fill(8'h90);
    v[50*8 +: 8] = 8'h03;
    single("t_post", v, 8'h03, 8'd50, 10'd7, 10'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
